// File: rtl/multicycle_control_fsm.sv
// Control sequencer for the multi-cycle CPU: walks each instruction through
// fetch/decode/execute/memory/writeback and decodes every datapath control from the state.
module multicycle_control_fsm #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op_i,
  input  logic       Mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic [3:0] State_o,
  output logic       Illegal_o
);

  typedef enum logic [3:0] {
    S_IF       = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_WB_MEM   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EX_R     = 4'd6,
    S_WB_R     = 4'd7,
    S_BEQ      = 4'd8,
    S_JUMP     = 4'd9,
    S_EX_I     = 4'd10,
    S_WB_I     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t state_reg;
  state_t state_next;
  logic   ready;

  assign ready   = !MEM_WAIT_EN || Mem_ready;
  assign State_o = state_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= S_IF;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = S_IF;
    case (state_reg)
      S_IF:       state_next = ready ? S_DECODE : S_IF;
      S_DECODE: begin
        case (Op_i)
          OP_RTYPE:      state_next = S_EX_R;
          OP_LW, OP_SW:  state_next = S_MEM_ADDR;
          OP_BEQ:        state_next = S_BEQ;
          OP_J:          state_next = S_JUMP;
          OP_ADDI:       state_next = S_EX_I;
          default:       state_next = S_IF;
        endcase
      end
      S_MEM_ADDR: begin
        if (Op_i == OP_LW)      state_next = S_MEM_RD;
        else if (Op_i == OP_SW) state_next = S_MEM_WR;
        else                    state_next = S_IF;
      end
      S_MEM_RD:   state_next = ready ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR:   state_next = ready ? S_IF : S_MEM_WR;
      S_EX_R:     state_next = S_WB_R;
      S_EX_I:     state_next = S_WB_I;
      default:    state_next = S_IF;
    endcase
  end

  // Reset forces every strobe low combinationally so an aborted access never completes.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    Illegal_o   = 1'b0;
    if (!reset) begin
      case (state_reg)
        S_IF: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = ready;
          PCWrite = ready;
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          case (Op_i)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: Illegal_o = 1'b0;
            default:                                       Illegal_o = 1'b1;
          endcase
        end
        S_MEM_ADDR, S_EX_I: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEM_RD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_WB_MEM: begin
          MemtoReg = 1'b1;
          RegWrite = ready;
        end
        S_MEM_WR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_EX_R: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        S_WB_R: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
        end
        S_BEQ: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        S_WB_I:  RegWrite = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
